// File: rtl/multich_pulse_counter_if.sv
// Snapshot readout bus: channel select, count, frame handshake and overrun.
interface multich_pulse_counter_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8
);
  localparam int unsigned SelW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [SelW-1:0]  rd_sel;
  logic [CNT_W-1:0] cnt_out;
  logic             frame_valid;
  logic             frame_ack;
  logic             overrun;

  modport master (
    input  rd_sel,
    input  frame_ack,
    output cnt_out,
    output frame_valid,
    output overrun
  );

  modport slave (
    output rd_sel,
    output frame_ack,
    input  cnt_out,
    input  frame_valid,
    input  overrun
  );
endinterface

// File: rtl/multich_pulse_counter.sv
// Gated multi-channel pulse counter with shadow snapshot frames and overrun flag.
// Define PULSE_CNT_SATURATE_EN to make live counters saturate instead of wrapping.
module multich_pulse_counter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned GATE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [GATE_W-1:0]       gate_len,
  input  logic [NUM_CH-1:0]       pulse_in,
  multich_pulse_counter_if.master rd
);

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  state_e            state_q;
  logic [GATE_W-1:0] timer_q;
  logic [NUM_CH-1:0] sync1_q, sync2_q, dly_q;
  logic [NUM_CH-1:0] edge_det;
  logic [CNT_W-1:0]  live_q   [NUM_CH];
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  live_inc [NUM_CH];
  logic              frame_valid_q, overrun_q;
  logic              window_end, can_load;

  always_comb begin
    edge_det = sync2_q & ~dly_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      live_inc[i] = live_q[i];
      if (edge_det[i]) begin
`ifdef PULSE_CNT_SATURATE_EN
        if (!(&live_q[i])) live_inc[i] = live_q[i] + CNT_W'(1);
`else
        live_inc[i] = live_q[i] + CNT_W'(1);
`endif
      end
    end
  end

  // Last cycle of the window; its own edges are already folded into live_inc.
  assign window_end = (state_q == StCount) && (timer_q == GATE_W'(1));
  assign can_load   = !frame_valid_q || rd.frame_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      sync1_q       <= '0;
      sync2_q       <= '0;
      dly_q         <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      sync1_q <= pulse_in;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;

      if (rd.frame_ack && frame_valid_q) begin
        frame_valid_q <= 1'b0;
        overrun_q     <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (en && (gate_len != '0)) begin
            state_q <= StCount;
            timer_q <= gate_len;
            for (int unsigned i = 0; i < NUM_CH; i++) live_q[i] <= '0;
          end
        end
        StCount: begin
          if (window_end) begin
            // A pending unacknowledged frame wins; the new one is dropped.
            if (can_load) begin
              for (int unsigned i = 0; i < NUM_CH; i++) shadow_q[i] <= live_inc[i];
              frame_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
            for (int unsigned i = 0; i < NUM_CH; i++) live_q[i] <= '0;
            if (en && (gate_len != '0)) begin
              timer_q <= gate_len;
            end else begin
              state_q <= StIdle;
              timer_q <= '0;
            end
          end else if (!en) begin
            state_q <= StIdle;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q - GATE_W'(1);
            for (int unsigned i = 0; i < NUM_CH; i++) live_q[i] <= live_inc[i];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    rd.cnt_out = '0;
    if (32'(rd.rd_sel) < NUM_CH) rd.cnt_out = shadow_q[rd.rd_sel];
  end

  assign rd.frame_valid = frame_valid_q;
  assign rd.overrun     = overrun_q;

endmodule
